// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shift_pkg;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b010,
      OP_SRA = 3'b011,
      OP_ROL = 3'b100,
      OP_ROR = 3'b101
   } shift_op_t;

   function automatic logic op_is_legal(input shift_op_t op);
      case (op)
         OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   // Number of mux levels handled by slice idx; earlier slices absorb the remainder.
   function automatic int slice_levels(input int stages, input int levels, input int idx);
      int base;
      int rem;
      base = levels / stages;
      rem  = levels % stages;
      return base + ((idx < rem) ? 1 : 0);
   endfunction

   // First mux level of slice idx; idx == stages yields the total level count.
   function automatic int slice_first(input int stages, input int levels, input int idx);
      int base;
      int rem;
      base = levels / stages;
      rem  = levels % stages;
      return idx * base + ((idx < rem) ? idx : rem);
   endfunction

endpackage

// File: rtl/shift_slice.sv
// Combinational group of barrel-shifter levels LVL_LO .. LVL_LO+LVL_N-1.
// Each level moves the word by 2^k; rotates reuse the same levels with wrap-around fill.
module shift_slice
   import shift_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int LVL_LO = 0,
   parameter int LVL_N  = 1
) (
   input  shift_op_t          op,
   input  logic [LVL_N-1:0]   shamt,
   input  logic [XLEN-1:0]    data_in,
   output logic [XLEN-1:0]    data_out
);

   function automatic logic [XLEN-1:0] shift_level(input shift_op_t sop,
                                                   input logic [XLEN-1:0] d,
                                                   input int amt);
      logic [XLEN-1:0] r;
      r = d;
      case (sop)
         OP_SLL:  r = d << amt;
         OP_SRL:  r = d >> amt;
         OP_SRA:  r = $signed(d) >>> amt;
         OP_ROL:  r = (d << amt) | (d >> (XLEN - amt));
         OP_ROR:  r = (d >> amt) | (d << (XLEN - amt));
         default: r = d;
      endcase
      return r;
   endfunction

   // Chain this slice's levels; a level passes data through when its shamt bit is clear.
   always_comb begin
      logic [XLEN-1:0] d;
      d = data_in;
      for (int k = 0; k < LVL_N; k++) begin
         if (shamt[k]) d = shift_level(op, d, 1 << (LVL_LO + k));
      end
      data_out = d;
   end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined shift/rotate unit with valid/ready flow control.
// Slice g computes its levels in front of register g; register STAGES-1 drives out_*.
// Illegal ops enter the pipe with zeroed data so every later level keeps the result at 0.
module shift_unit_pipe
   import shift_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAGW   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  shift_op_t               in_op,
   input  logic [$clog2(XLEN)-1:0] in_shamt,
   input  logic [XLEN-1:0]         in_data,
   input  logic [TAGW-1:0]         in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_data,
   output logic [TAGW-1:0]         out_tag,
   output logic                    out_err
);

   localparam int SHW = $clog2(XLEN);

   logic [STAGES-1:0] valid_vec;
   logic [STAGES-1:0] adv;

   for (genvar g = 0; g < STAGES; g++) begin : g_st
      localparam int LO  = slice_first(STAGES, SHW, g);
      localparam int N   = slice_levels(STAGES, SHW, g);
      localparam int NXT = LO + N;

      logic                v_in;
      logic [XLEN-1:0]     d_in;
      logic [XLEN-1:0]     d_sl;
      shift_op_t           o_in;
      logic [TAGW-1:0]     t_in;
      logic [SHW-1:LO]     sh_in;

      logic                vq;
      logic [XLEN-1:0]     dq;
      shift_op_t           oq;
      logic [TAGW-1:0]     tq;

      if (g == 0) begin : g_src
         assign v_in  = in_valid;
         assign d_in  = op_is_legal(in_op) ? in_data : '0;
         assign o_in  = in_op;
         assign t_in  = in_tag;
         assign sh_in = in_shamt;
      end else begin : g_src
         assign v_in  = g_st[g-1].vq;
         assign d_in  = g_st[g-1].dq;
         assign o_in  = g_st[g-1].oq;
         assign t_in  = g_st[g-1].tq;
         assign sh_in = g_st[g-1].g_rem.sh_q;
      end

      // A stage advances when it or any stage downstream of it has a hole, or the sink takes.
      assign valid_vec[g] = vq;
      assign adv[g]       = out_ready | ~(&valid_vec[STAGES-1:g]);

      shift_slice #(
         .XLEN   (XLEN),
         .LVL_LO (LO),
         .LVL_N  (N)
      ) u_slice (
         .op       (o_in),
         .shamt    (sh_in[LO +: N]),
         .data_in  (d_in),
         .data_out (d_sl)
      );

      // Stage register: loads on advance, holds otherwise so a stalled output stays stable.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vq <= 1'b0;
            dq <= '0;
            oq <= OP_SLL;
            tq <= '0;
         end else if (adv[g]) begin
            vq <= v_in;
            dq <= d_sl;
            oq <= o_in;
            tq <= t_in;
         end
      end

      if (NXT < SHW) begin : g_rem
         logic [SHW-1:NXT] sh_q;

         // Carry only the shift-amount bits that later slices still need.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sh_q <= '0;
            else if (adv[g]) sh_q <= sh_in[SHW-1:NXT];
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = g_st[STAGES-1].vq;
   assign out_data  = g_st[STAGES-1].dq;
   assign out_tag   = g_st[STAGES-1].tq;
   assign out_err   = ~op_is_legal(g_st[STAGES-1].oq);

endmodule
